// File: rtl/ghost_catch_monitor_pkg.sv
// Shared encodings and widths for the ghost catch monitor.
package ghost_catch_monitor_pkg;

   localparam int X_W = 10;
   localparam int Y_W = 9;

   localparam logic [X_W-1:0] HIT_R_DEFAULT = 10'd12;

   typedef enum logic [1:0] {
      ST_PLAY    = 2'd0,
      ST_CAUGHT  = 2'd1,
      ST_RESPAWN = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

endpackage

// File: rtl/ghost_catch_monitor_overlap_check.sv
// Per-ghost overlap: both axis distances strictly inside the catch radius.
// Purely combinational; the caller registers the result.
module ghost_catch_monitor_overlap_check
   import ghost_catch_monitor_pkg::*;
#(
   parameter logic [X_W-1:0] HIT_R = HIT_R_DEFAULT
) (
   input  logic [X_W-1:0] i_pac_x,
   input  logic [Y_W-1:0] i_pac_y,
   input  logic [X_W-1:0] i_g_x,
   input  logic [Y_W-1:0] i_g_y,
   output logic           o_hit
);

   logic [X_W-1:0] w_dx;
   logic [Y_W-1:0] w_dy;

   // Larger minus smaller keeps the difference non-negative at operand width.
   assign w_dx = (i_pac_x >= i_g_x) ? (i_pac_x - i_g_x) : (i_g_x - i_pac_x);
   assign w_dy = (i_pac_y >= i_g_y) ? (i_pac_y - i_g_y) : (i_g_y - i_pac_y);

   assign o_hit = (w_dx < HIT_R) && (X_W'(w_dy) < HIT_R);

endmodule

// File: rtl/ghost_catch_monitor.sv
// Catch monitor: detects Pacman/ghost overlap, deducts lives, sequences freeze and respawn.
// All outputs registered; state changes one cycle after the triggering input.
module ghost_catch_monitor
   import ghost_catch_monitor_pkg::*;
#(
   parameter logic [X_W-1:0] HIT_R        = HIT_R_DEFAULT,
   parameter logic [7:0]     FREEZE_TICKS = 8'd120,
   parameter logic [1:0]     START_LIVES  = 2'd3
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_move_tick,
   input  logic [X_W-1:0] i_pac_x,
   input  logic [Y_W-1:0] i_pac_y,
   input  logic [X_W-1:0] i_g0_x,
   input  logic [Y_W-1:0] i_g0_y,
   input  logic [X_W-1:0] i_g1_x,
   input  logic [Y_W-1:0] i_g1_y,
   input  logic [X_W-1:0] i_g2_x,
   input  logic [Y_W-1:0] i_g2_y,
   input  logic           i_restart,
   output logic [1:0]     o_state,
   output logic [1:0]     o_lives,
   output logic           o_freeze,
   output logic           o_respawn,
   output logic [2:0]     o_hit_ghost
);

   logic [2:0] w_hit;
   state_t     r_state;
   logic [1:0] r_lives;
   logic [7:0] r_cnt;
   logic       r_freeze;
   logic       r_respawn;
   logic [2:0] r_hit;

   ghost_catch_monitor_overlap_check #(.HIT_R(HIT_R)) u_overlap_check_g0 (
      .i_pac_x (i_pac_x),
      .i_pac_y (i_pac_y),
      .i_g_x   (i_g0_x),
      .i_g_y   (i_g0_y),
      .o_hit   (w_hit[0])
   );

   ghost_catch_monitor_overlap_check #(.HIT_R(HIT_R)) u_overlap_check_g1 (
      .i_pac_x (i_pac_x),
      .i_pac_y (i_pac_y),
      .i_g_x   (i_g1_x),
      .i_g_y   (i_g1_y),
      .o_hit   (w_hit[1])
   );

   ghost_catch_monitor_overlap_check #(.HIT_R(HIT_R)) u_overlap_check_g2 (
      .i_pac_x (i_pac_x),
      .i_pac_y (i_pac_y),
      .i_g_x   (i_g2_x),
      .i_g_y   (i_g2_y),
      .o_hit   (w_hit[2])
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_PLAY;
         r_lives   <= START_LIVES;
         r_cnt     <= '0;
         r_freeze  <= 1'b0;
         r_respawn <= 1'b0;
         r_hit     <= '0;
      end else begin
         r_hit     <= w_hit;
         r_respawn <= 1'b0;
         case (r_state)
            ST_PLAY: begin
               // Any number of simultaneous overlaps costs a single life.
               if (|w_hit) begin
                  r_freeze <= 1'b1;
                  r_cnt    <= FREEZE_TICKS;
                  if (r_lives <= 2'd1) begin
                     r_lives <= 2'd0;
                     r_state <= ST_OVER;
                  end else begin
                     r_lives <= r_lives - 2'd1;
                     r_state <= ST_CAUGHT;
                  end
               end
            end
            ST_CAUGHT: begin
               if (i_move_tick) begin
                  if (r_cnt <= 8'd1) begin
                     r_cnt     <= '0;
                     r_state   <= ST_RESPAWN;
                     r_respawn <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            ST_RESPAWN: begin
               r_state  <= ST_PLAY;
               r_freeze <= 1'b0;
            end
            default: begin
               if (i_restart) begin
                  r_lives   <= START_LIVES;
                  r_state   <= ST_RESPAWN;
                  r_respawn <= 1'b1;
               end
            end
         endcase
      end
   end

   assign o_state     = r_state;
   assign o_lives     = r_lives;
   assign o_freeze    = r_freeze;
   assign o_respawn   = r_respawn;
   assign o_hit_ghost = r_hit;

endmodule

// File: tb/tb_ghost_catch_monitor.sv
// Bench for ghost_catch_monitor: directed scenarios plus random play against a rule-level model.
module tb_ghost_catch_monitor;

   localparam logic [9:0] P_HIT = 10'd12;
   localparam logic [7:0] P_FRZ = 8'd4;
   localparam logic [1:0] P_LIV = 2'd3;

   localparam int M_PLAY = 0, M_CAUGHT = 1, M_RESPAWN = 2, M_OVER = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       restart;
   logic [9:0] px;
   logic [8:0] py;
   logic [9:0] gx [3];
   logic [8:0] gy [3];
   logic [1:0] o_state;
   logic [1:0] o_lives;
   logic       o_freeze;
   logic       o_respawn;
   logic [2:0] o_hit;

   int n_chk = 0;
   int n_bad = 0;

   int       m_state;
   int       m_lives;
   int       m_left;
   bit [2:0] m_hit;
   bit       m_resp;

   always #5 clk = ~clk;

   ghost_catch_monitor #(
      .HIT_R        (P_HIT),
      .FREEZE_TICKS (P_FRZ),
      .START_LIVES  (P_LIV)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_move_tick (tick),
      .i_pac_x     (px),
      .i_pac_y     (py),
      .i_g0_x      (gx[0]),
      .i_g0_y      (gy[0]),
      .i_g1_x      (gx[1]),
      .i_g1_y      (gy[1]),
      .i_g2_x      (gx[2]),
      .i_g2_y      (gy[2]),
      .i_restart   (restart),
      .o_state     (o_state),
      .o_lives     (o_lives),
      .o_freeze    (o_freeze),
      .o_respawn   (o_respawn),
      .o_hit_ghost (o_hit)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ovl(input int ax, input int ay, input int bx, input int by);
      int dx, dy;
      dx = ax - bx;
      dy = ay - by;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (dx < int'(P_HIT)) && (dy < int'(P_HIT));
   endfunction

   task automatic model_reset();
      m_state = M_PLAY;
      m_lives = int'(P_LIV);
      m_left  = 0;
      m_hit   = '0;
      m_resp  = 1'b0;
   endtask

   task automatic check_all(input string pfx);
      chk({pfx, "_state"},   32'(o_state),   m_state);
      chk({pfx, "_lives"},   32'(o_lives),   m_lives);
      chk({pfx, "_freeze"},  32'(o_freeze),  (m_state != M_PLAY) ? 1 : 0);
      chk({pfx, "_respawn"}, 32'(o_respawn), 32'(m_resp));
      chk({pfx, "_hit"},     32'(o_hit),     32'(m_hit));
   endtask

   // Advances the model by the rules for the current inputs, then one clock.
   task automatic step(input string pfx);
      bit [2:0] h;
      bit       resp;
      for (int i = 0; i < 3; i++)
         h[i] = ovl(int'(px), int'(py), int'(gx[i]), int'(gy[i]));
      resp = 1'b0;
      case (m_state)
         M_PLAY: if (h != 0) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_state = (m_lives == 0) ? M_OVER : M_CAUGHT;
            m_left  = int'(P_FRZ);
         end
         M_CAUGHT: if (tick) begin
            if (m_left <= 1) begin
               m_state = M_RESPAWN;
               resp    = 1'b1;
            end else begin
               m_left--;
            end
         end
         M_RESPAWN: m_state = M_PLAY;
         default: if (restart) begin
            m_lives = int'(P_LIV);
            m_state = M_RESPAWN;
            resp    = 1'b1;
         end
      endcase
      m_hit  = h;
      m_resp = resp;
      @(posedge clk);
      #1;
      check_all(pfx);
   endtask

   task automatic place(input int i, input int x, input int y);
      gx[i] = 10'(x);
      gy[i] = 9'(y);
   endtask

   task automatic all_far();
      place(0, 600, 400);
      place(1, 700, 450);
      place(2, 800, 500);
   endtask

   task automatic finish_freeze(input string pfx);
      for (int k = 0; k < int'(P_FRZ); k++) begin
         step(pfx);
         step(pfx);
         tick = 1'b1;
         step(pfx);
         tick = 1'b0;
      end
      chk({pfx, "_rsp_pulse"}, 32'(o_respawn), 1);
      step(pfx);
      chk({pfx, "_back_play"}, 32'(o_state), M_PLAY);
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   initial begin
      rst_n   = 1'b0;
      tick    = 1'b0;
      restart = 1'b0;
      px      = 10'd100;
      py      = 9'd100;
      all_far();
      model_reset();
      #12;
      check_all("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Radius boundary: distance 12 misses, 11 catches.
      place(0, 112, 100);
      step("r12");
      chk("r12_nohit", 32'(o_hit), 0);
      place(0, 111, 100);
      step("r11");
      chk("r11_hit", 32'(o_hit), 1);
      chk("r11_lives", 32'(o_lives), 2);
      chk("r11_caught", 32'(o_state), M_CAUGHT);
      // Overlap held through the freeze and the respawn cycle is free.
      for (int k = 0; k < int'(P_FRZ); k++) begin
         for (int c = 0; c < 9; c++) step("frz");
         chk("frz_still_caught", 32'(o_state), M_CAUGHT);
         tick = 1'b1;
         step("frz_tick");
         tick = 1'b0;
      end
      chk("frz_respawn_state", 32'(o_state), M_RESPAWN);
      chk("frz_respawn_pulse", 32'(o_respawn), 1);
      step("frz_rsp");
      chk("frz_play", 32'(o_state), M_PLAY);
      chk("frz_lives_kept", 32'(o_lives), 2);
      all_far();
      step("idle");

      // Two ghosts at once cost one life.
      place(0, 100, 100);
      place(2, 100, 100);
      step("dual");
      chk("dual_hit", 32'(o_hit), 3'b101);
      chk("dual_lives", 32'(o_lives), 1);
      all_far();
      finish_freeze("dual");

      // Last life lost, overlap persists in OVER, restart wins over overlap.
      place(1, 95, 98);
      step("over");
      chk("over_state", 32'(o_state), M_OVER);
      chk("over_lives", 32'(o_lives), 0);
      chk("over_freeze", 32'(o_freeze), 1);
      for (int c = 0; c < 5; c++) step("over_hold");
      chk("over_sat", 32'(o_lives), 0);
      restart = 1'b1;
      step("restart");
      restart = 1'b0;
      chk("restart_lives", 32'(o_lives), 3);
      chk("restart_state", 32'(o_state), M_RESPAWN);
      all_far();
      step("restart_play");

      // Absolute difference in both directions and at the far corner.
      px = 10'd5; py = 9'd5; place(1, 0, 0);
      step("abs_a");
      chk("abs_a_hit", 32'(o_hit), 3'b010);
      px = 10'd0; py = 9'd0; place(1, 5, 5);
      step("abs_b");
      chk("abs_b_hit", 32'(o_hit), 3'b010);
      px = 10'd1023; py = 9'd511; place(1, 0, 0);
      step("abs_c");
      chk("abs_c_hit", 32'(o_hit), 0);

      // Asynchronous reset while frozen: no edge needed, no respawn after.
      chk("pre_rst_caught", 32'(o_state), M_CAUGHT);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(posedge clk);
      #1;
      check_all("arst_hold");
      rst_n = 1'b1;
      px = 10'd100; py = 9'd100;
      all_far();
      for (int c = 0; c < 8; c++) step("post_rst");

      // Tick coinciding with the catch does not shorten the freeze.
      place(0, 100, 100);
      tick = 1'b1;
      step("tick_catch");
      tick = 1'b0;
      all_far();
      finish_freeze("tick_catch");

      // Random play.
      for (int n = 0; n < 3000; n++) begin
         px = 10'($urandom_range(0, 1023));
         py = 9'($urandom_range(0, 511));
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 3) == 0)
               place(i, clampi(int'(px) + int'($urandom_range(0, 30)) - 15, 1023),
                        clampi(int'(py) + int'($urandom_range(0, 30)) - 15, 511));
            else
               place(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
         end
         tick    = ($urandom_range(0, 2) == 0);
         restart = ($urandom_range(0, 5) == 0);
         step("rnd");
      end
      tick    = 1'b0;
      restart = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ghost_catch_monitor.md
GHOST_CATCH_MONITOR -- requirements
Module: ghost_catch_monitor

Interface
REQ-001 Parameter HIT_R, default 10'd12: catch radius in pixels, applied per axis.
REQ-002 Parameter FREEZE_TICKS, default 8'd120: move_tick count that play stays frozen after a catch.
REQ-003 Parameter START_LIVES, default 2'd3: lives loaded at reset and on restart.
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 move_tick  in  1  one-cycle pulse, the same cadence as the ghost movement step.
REQ-007 pac_x  in  10, pac_y  in  9: Pacman position.
REQ-008 g0_x/g1_x/g2_x  in  10 each, g0_y/g1_y/g2_y  in  9 each: ghost positions.
REQ-009 restart  in  1  level-sampled; leaves OVER.
REQ-010 state  out  2  PLAY=0, CAUGHT=1, RESPAWN=2, OVER=3.
REQ-011 lives  out  2  remaining lives.
REQ-012 freeze  out  1  high in CAUGHT, RESPAWN and OVER; movers hold position while it is high.
REQ-013 respawn  out  1  one-cycle pulse; movers reload their start positions.
REQ-014 hit_ghost  out  3  registered per-ghost overlap flags, bit i = ghost i.

Function
REQ-015 Ghost i overlaps when |pac_x-gi_x| < HIT_R and |pac_y-gi_y| < HIT_R.
REQ-016 Each absolute difference SHALL use an unsigned subtraction of the larger minus the smaller, at the operand width (10 or 9 bits); no wrap is possible.
REQ-017 hit_ghost SHALL register the combinational overlap flags every cycle in every state, so it has 1-cycle latency.
REQ-018 PLAY: if any overlap exists in cycle N, at N+1 lives decrements by 1 and state becomes CAUGHT, or OVER if lives becomes 0.
REQ-019 Multiple ghosts overlapping in the same cycle cost exactly one life.
REQ-020 On entry to CAUGHT, the freeze counter loads FREEZE_TICKS; each move_tick decrements it.
REQ-021 When a move_tick arrives with the counter at 1 or 0, CAUGHT moves to RESPAWN. FREEZE_TICKS=0 therefore behaves as 1.
REQ-022 RESPAWN SHALL last exactly one cycle, assert respawn during that cycle, then go to PLAY.
REQ-023 Overlaps SHALL be ignored for state and lives in CAUGHT, RESPAWN and OVER.
REQ-024 In PLAY, the first evaluated cycle is the one after the RESPAWN cycle.
REQ-025 OVER: restart=1 in cycle N gives, at N+1, lives=START_LIVES, state=RESPAWN, and a respawn pulse, followed by PLAY.
REQ-026 restart SHALL be ignored outside OVER.
REQ-027 OVER with simultaneous overlap and restart: restart wins and no life is deducted.
REQ-028 A move_tick coinciding with a PLAY hit SHALL NOT decrement the newly loaded counter.
REQ-029 lives SHALL never underflow; it saturates at 0 in OVER.

Reset
REQ-030 While rst=0, asynchronously: state=PLAY, lives=START_LIVES, freeze counter=0, freeze=0, respawn=0, hit_ghost=0.
REQ-031 Reset asserted mid-CAUGHT SHALL abort the freeze with no respawn pulse.
REQ-032 Reset release SHALL be sampled on clk, so the first transition happens one cycle after release.
REQ-033 All outputs SHALL be registered, none combinational from inputs.

Structure
REQ-034 The shared package SHALL hold the state encodings (PLAY/CAUGHT/RESPAWN/OVER), the position widths (10/9) and the default HIT_R.
REQ-035 One sub-module, overlap_check, SHALL be instantiated 3 times: per-ghost abs-difference compare, combinational, parameterised by HIT_R.
REQ-036 A single always block holds the FSM, lives and freeze counter.

Verification
REQ-037 Pac (100,100), g0 (111,100), others far, PLAY lives=3 -> hit_ghost=001 and state=CAUGHT and lives=2 one cycle later; g0 at (112,100) -> no hit.
REQ-038 g0 and g2 both at pac, lives=3 -> lives=2 only and hit_ghost=101.
REQ-039 FREEZE_TICKS=4, catch then 4 move_ticks spaced 10 cycles -> CAUGHT until the 4th tick, RESPAWN for 1 cycle with respawn=1, then PLAY; overlaps held during CAUGHT cost nothing.
REQ-040 lives=1, catch -> state=OVER, lives=0, freeze=1; overlap persists -> lives stays 0; restart=1 -> lives=3, RESPAWN, then PLAY.
REQ-041 Pac (5,5), g1 (0,0) and pac (0,0), g1 (5,5), HIT_R=6 -> both hit; pac (1023,511), g1 (0,0) -> no hit.
REQ-042 rst=0 asynchronously mid-CAUGHT (no clock edge) -> outputs reach reset values immediately; after release state=PLAY, lives=3, and respawn never pulses.
